// File: rtl/vx_interrupt_controller_pkg.sv
// Shared types and constants for the interrupt controller and its counter.
package vx_interrupt_controller_pkg;

   localparam int NUM_THREADS = 4;
   localparam int NUM_WARPS   = 4;
   localparam int XLEN        = 32;

   // Sequencing phases presented to the thread transfer unit.
   typedef enum logic [2:0] {
      IRQC_IDLE        = 3'd0,
      IRQC_WAIT        = 3'd1,
      IRQC_PC_SWAP     = 3'd2,
      IRQC_WAIT_ISR    = 3'd3,
      IRQC_REVERT_WARP = 3'd4
   } irqc_state_e;

   localparam logic [1:0] IRQ_RSP_DONE      = 2'd0;
   localparam logic [1:0] IRQ_RSP_NOT_FOUND = 2'd1;
   localparam logic [1:0] IRQ_RSP_TIMEOUT   = 2'd2;

   // Width needed to index n items, never less than one bit.
   function automatic int log2up(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_interrupt_controller_timeout_counter.sv
// Up-counter bounding the time spent waiting for the pipeline to drain.
module vx_interrupt_controller_timeout_counter
   import vx_interrupt_controller_pkg::*;
#(
   parameter int LIMIT = 1024,
   parameter int WIDTH = log2up(LIMIT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   logic [WIDTH-1:0] count;

   // Count enabled cycles since the last clear.
   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable)
         count <= count + WIDTH'(1);
   end

   // Expiry is only meaningful while counting.
   assign expire = enable && (count == LAST);

endmodule

// File: rtl/vx_interrupt_controller.sv
// Interrupt controller: pulls one thread out of a warp, runs an ISR on it
// through the thread transfer unit, then restores the warp and reports back.
//
// state            | meaning
// IRQC_IDLE        | ready for a request, or holding an unconsumed response
// IRQC_WAIT        | waiting for pipeline drain, bounded by WAIT_TIMEOUT
// IRQC_PC_SWAP     | one cycle, TTU loads the ISR entry PC
// IRQC_WAIT_ISR    | ISR running, no time bound
// IRQC_REVERT_WARP | one cycle, TTU restores saved PC and masks
module vx_interrupt_controller
   import vx_interrupt_controller_pkg::*;
#(
   parameter int THREAD_CNT     = NUM_THREADS,
   parameter int WARP_CNT       = NUM_WARPS,
   parameter int WARP_CNT_WIDTH = log2up(WARP_CNT),
   parameter int TID_WIDTH      = log2up(THREAD_CNT),
   parameter int WAIT_TIMEOUT   = 1024
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      irq_req_valid,
   output logic                      irq_req_ready,
   input  logic [WARP_CNT_WIDTH-1:0] irq_req_wid,
   input  logic [TID_WIDTH-1:0]      irq_req_tid,
   input  logic [XLEN-1:0]           irq_req_isr_pc,

   output logic                      irq_rsp_valid,
   input  logic                      irq_rsp_ready,
   output logic [1:0]                irq_rsp_status,
   output logic [XLEN-1:0]           irq_rsp_pc,

   output logic                      busy,

   output irqc_state_e               ttu_state,
   output logic [WARP_CNT_WIDTH-1:0] ttu_wid,
   output logic [TID_WIDTH-1:0]      ttu_tid,
   output logic [XLEN-1:0]           ttu_load_pc,
   output logic [THREAD_CNT-1:0]     ttu_load_tmask,
   output logic [WARP_CNT-1:0]       ttu_load_wmask,
   input  logic                      ttu_pipeline_drained,
   input  logic                      ttu_thread_found,
   input  logic [THREAD_CNT-1:0]     ttu_current_thread_mask,
   input  logic [XLEN-1:0]           ttu_current_pc,
   input  logic [WARP_CNT-1:0]       ttu_current_active_warps,
   input  logic                      ttu_isr_done
);

   irqc_state_e           state;
   logic [XLEN-1:0]       isr_pc;
   logic [XLEN-1:0]       saved_pc;
   logic [THREAD_CNT-1:0] saved_tmask;
   logic [WARP_CNT-1:0]   saved_wmask;
   logic                  accept;
   logic                  expire;

   assign irq_req_ready = (state == IRQC_IDLE) && !irq_rsp_valid;
   assign accept        = irq_req_valid && irq_req_ready;
   assign busy          = (state != IRQC_IDLE);
   assign ttu_state     = state;

   vx_interrupt_controller_timeout_counter #(
      .LIMIT (WAIT_TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept),
      .enable (state == IRQC_WAIT),
      .expire (expire)
   );

   // Transaction sequencer; all TTU-facing values are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IRQC_IDLE;
         ttu_wid        <= '0;
         ttu_tid        <= '0;
         isr_pc         <= '0;
         saved_pc       <= '0;
         saved_tmask    <= '0;
         saved_wmask    <= '0;
         ttu_load_pc    <= '0;
         ttu_load_tmask <= '0;
         ttu_load_wmask <= '0;
         irq_rsp_valid  <= 1'b0;
         irq_rsp_status <= IRQ_RSP_DONE;
         irq_rsp_pc     <= '0;
      end else begin
         case (state)
            IRQC_IDLE: begin
               if (irq_rsp_valid) begin
                  if (irq_rsp_ready)
                     irq_rsp_valid <= 1'b0;
               end else if (irq_req_valid) begin
                  ttu_wid <= irq_req_wid;
                  ttu_tid <= irq_req_tid;
                  isr_pc  <= irq_req_isr_pc;
                  state   <= IRQC_WAIT;
               end
            end
            IRQC_WAIT: begin
               // A drain seen on the expiry cycle still wins.
               if (ttu_pipeline_drained) begin
                  if (ttu_thread_found) begin
                     saved_pc    <= ttu_current_pc;
                     saved_tmask <= ttu_current_thread_mask;
                     saved_wmask <= ttu_current_active_warps;
                     ttu_load_pc <= isr_pc;
                     state       <= IRQC_PC_SWAP;
                  end else begin
                     irq_rsp_valid  <= 1'b1;
                     irq_rsp_status <= IRQ_RSP_NOT_FOUND;
                     irq_rsp_pc     <= '0;
                     state          <= IRQC_IDLE;
                  end
               end else if (expire) begin
                  irq_rsp_valid  <= 1'b1;
                  irq_rsp_status <= IRQ_RSP_TIMEOUT;
                  irq_rsp_pc     <= '0;
                  state          <= IRQC_IDLE;
               end
            end
            IRQC_PC_SWAP: begin
               state <= IRQC_WAIT_ISR;
            end
            IRQC_WAIT_ISR: begin
               if (ttu_isr_done) begin
                  ttu_load_pc    <= saved_pc;
                  ttu_load_tmask <= saved_tmask;
                  ttu_load_wmask <= saved_wmask;
                  state          <= IRQC_REVERT_WARP;
               end
            end
            IRQC_REVERT_WARP: begin
               irq_rsp_valid  <= 1'b1;
               irq_rsp_status <= IRQ_RSP_DONE;
               irq_rsp_pc     <= saved_pc;
               state          <= IRQC_IDLE;
            end
            default: state <= IRQC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vx_interrupt_controller.sv
// Self-checking bench for vx_interrupt_controller with a small TTU model.
module tb_vx_interrupt_controller;
   import vx_interrupt_controller_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq_req_valid, irq_req_ready;
   logic [1:0]  irq_req_wid, irq_req_tid;
   logic [31:0] irq_req_isr_pc;
   logic        irq_rsp_valid, irq_rsp_ready;
   logic [1:0]  irq_rsp_status;
   logic [31:0] irq_rsp_pc;
   logic        busy;
   irqc_state_e ttu_state;
   logic [1:0]  ttu_wid, ttu_tid;
   logic [31:0] ttu_load_pc;
   logic [3:0]  ttu_load_tmask, ttu_load_wmask;
   logic        ttu_pipeline_drained, ttu_thread_found, ttu_isr_done;
   logic [3:0]  ttu_current_thread_mask, ttu_current_active_warps;
   logic [31:0] ttu_current_pc;

   int checks = 0;
   int errors = 0;

   vx_interrupt_controller #(
      .THREAD_CNT   (4),
      .WARP_CNT     (4),
      .WAIT_TIMEOUT (TO)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .irq_req_valid            (irq_req_valid),
      .irq_req_ready            (irq_req_ready),
      .irq_req_wid              (irq_req_wid),
      .irq_req_tid              (irq_req_tid),
      .irq_req_isr_pc           (irq_req_isr_pc),
      .irq_rsp_valid            (irq_rsp_valid),
      .irq_rsp_ready            (irq_rsp_ready),
      .irq_rsp_status           (irq_rsp_status),
      .irq_rsp_pc               (irq_rsp_pc),
      .busy                     (busy),
      .ttu_state                (ttu_state),
      .ttu_wid                  (ttu_wid),
      .ttu_tid                  (ttu_tid),
      .ttu_load_pc              (ttu_load_pc),
      .ttu_load_tmask           (ttu_load_tmask),
      .ttu_load_wmask           (ttu_load_wmask),
      .ttu_pipeline_drained     (ttu_pipeline_drained),
      .ttu_thread_found         (ttu_thread_found),
      .ttu_current_thread_mask  (ttu_current_thread_mask),
      .ttu_current_pc           (ttu_current_pc),
      .ttu_current_active_warps (ttu_current_active_warps),
      .ttu_isr_done             (ttu_isr_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  wid;
      logic [1:0]  tid;
      logic [31:0] isr_pc;
      int          d;          // WAIT cycle index at which drain is first seen
      bit          found;
      logic [31:0] cur_pc;
      logic [3:0]  tmask;
      logic [3:0]  wmask;
      int          isr_delay;  // WAIT_ISR cycles before ISR_done
      int          hold;       // cycles of response backpressure
      logic [1:0]  exp_status;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] wid, input logic [1:0] tid,
                               input logic [31:0] isr_pc, input int d, input bit found,
                               input logic [31:0] cur_pc, input logic [3:0] tmask,
                               input logic [3:0] wmask, input int isr_delay, input int hold,
                               input logic [1:0] exp_status, input logic [31:0] exp_pc);
      vec_t v;
      v.wid = wid; v.tid = tid; v.isr_pc = isr_pc; v.d = d; v.found = found;
      v.cur_pc = cur_pc; v.tmask = tmask; v.wmask = wmask; v.isr_delay = isr_delay;
      v.hold = hold; v.exp_status = exp_status; v.exp_pc = exp_pc;
      return v;
   endfunction

   // Reference outcome of a pull from the operation rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.d > TO - 1) begin
         r.exp_status = IRQ_RSP_TIMEOUT; r.exp_pc = '0;
      end else if (!v.found) begin
         r.exp_status = IRQ_RSP_NOT_FOUND; r.exp_pc = '0;
      end else begin
         r.exp_status = IRQ_RSP_DONE; r.exp_pc = v.cur_pc;
      end
      return r;
   endfunction

   // Phase expected c cycles after entering WAIT (before the response cycle).
   function automatic irqc_state_e exp_phase(input int c, input int d, input int k);
      if (d > TO - 1 || c <= d) return IRQC_WAIT;
      if (c == d + 1) return IRQC_PC_SWAP;
      if (c <= k) return IRQC_WAIT_ISR;
      return IRQC_REVERT_WARP;
   endfunction

   task automatic run_txn(input vec_t v);
      int  k;
      int  rsp_cycle;
      bit  swap;
      irqc_state_e es;
      swap = v.found && (v.d <= TO - 1);
      k    = v.d + 2 + v.isr_delay;
      if (swap) rsp_cycle = k + 2;
      else if (v.d <= TO - 1) rsp_cycle = v.d + 1;
      else rsp_cycle = TO;

      @(negedge clk);
      chk("req_ready_idle", irq_req_ready, 1);
      irq_req_valid  = 1'b1;
      irq_req_wid    = v.wid;
      irq_req_tid    = v.tid;
      irq_req_isr_pc = v.isr_pc;
      @(negedge clk);
      irq_req_valid  = 1'b0;
      irq_req_wid    = ~v.wid;
      irq_req_tid    = ~v.tid;
      chk("busy_wait", busy, 1);
      chk("wid_held", ttu_wid, v.wid);
      chk("tid_held", ttu_tid, v.tid);

      for (int c = 0; c < rsp_cycle; c++) begin
         es = exp_phase(c, v.d, k);
         chk("phase", ttu_state, es);
         if (es == IRQC_PC_SWAP) chk("swap_load_pc", ttu_load_pc, v.isr_pc);
         if (es == IRQC_REVERT_WARP) begin
            chk("revert_load_pc", ttu_load_pc, v.cur_pc);
            chk("revert_tmask", ttu_load_tmask, v.tmask);
            chk("revert_wmask", ttu_load_wmask, v.wmask);
         end
         ttu_pipeline_drained     = (c >= v.d);
         ttu_thread_found         = v.found;
         ttu_current_pc           = v.cur_pc;
         ttu_current_thread_mask  = v.tmask;
         ttu_current_active_warps = v.wmask;
         ttu_isr_done             = swap && (c >= k);
         @(negedge clk);
      end
      ttu_pipeline_drained = 1'b0;
      ttu_isr_done         = 1'b0;
      ttu_current_pc       = 32'hdead_beef;

      chk("rsp_state_idle", ttu_state, IRQC_IDLE);
      chk("rsp_valid", irq_rsp_valid, 1);
      chk("rsp_status", irq_rsp_status, v.exp_status);
      if (v.exp_status == IRQ_RSP_DONE) chk("rsp_pc", irq_rsp_pc, v.exp_pc);
      chk("busy_idle", busy, 0);
      chk("req_ready_pending", irq_req_ready, 0);
      chk("wid_retained", ttu_wid, v.wid);

      for (int h = 0; h < v.hold; h++) begin
         irq_rsp_ready  = 1'b0;
         irq_req_valid  = 1'b1;
         irq_req_isr_pc = 32'h1234_5678;
         @(negedge clk);
         chk("bp_rsp_valid", irq_rsp_valid, 1);
         chk("bp_status", irq_rsp_status, v.exp_status);
         if (v.exp_status == IRQ_RSP_DONE) chk("bp_pc", irq_rsp_pc, v.exp_pc);
         chk("bp_req_ready", irq_req_ready, 0);
         chk("bp_no_accept", ttu_state, IRQC_IDLE);
      end
      irq_req_valid = 1'b0;
      irq_rsp_ready = 1'b1;
      @(negedge clk);
      irq_rsp_ready = 1'b0;
      chk("rsp_consumed", irq_rsp_valid, 0);
      chk("req_ready_again", irq_req_ready, 1);
   endtask

   initial begin
      vec_t v;
      reset = 1'b1;
      irq_req_valid = 0; irq_req_wid = 0; irq_req_tid = 0; irq_req_isr_pc = 0;
      irq_rsp_ready = 0;
      ttu_pipeline_drained = 0; ttu_thread_found = 0; ttu_isr_done = 0;
      ttu_current_pc = 0; ttu_current_thread_mask = 0; ttu_current_active_warps = 0;

      tbl[0] = mk(2'd1, 2'd2, 32'h8000_1000,    5, 1, 32'h8000_0040, 4'hF, 4'h3, 18,  0, IRQ_RSP_DONE,      32'h8000_0040);
      tbl[1] = mk(2'd3, 2'd1, 32'h8000_2000,    3, 0, 32'h8000_0100, 4'h5, 4'h1,  0,  0, IRQ_RSP_NOT_FOUND, 32'h0);
      tbl[2] = mk(2'd0, 2'd3, 32'h8000_3000, 1000, 1, 32'h8000_0200, 4'h1, 4'h1,  0,  0, IRQ_RSP_TIMEOUT,   32'h0);
      tbl[3] = mk(2'd2, 2'd0, 32'h8000_4000,   15, 1, 32'h8000_0300, 4'hA, 4'h6,  2,  0, IRQ_RSP_DONE,      32'h8000_0300);
      tbl[4] = mk(2'd1, 2'd1, 32'h8000_5000,   15, 0, 32'h8000_0400, 4'h3, 4'h2,  0,  0, IRQ_RSP_NOT_FOUND, 32'h0);
      tbl[5] = mk(2'd3, 2'd3, 32'h8000_6000,    0, 1, 32'h8000_0500, 4'h8, 4'h8,  0,  0, IRQ_RSP_DONE,      32'h8000_0500);
      tbl[6] = mk(2'd2, 2'd2, 32'h8000_7000,    4, 1, 32'h8000_0600, 4'h7, 4'hC,  3, 10, IRQ_RSP_DONE,      32'h8000_0600);
      tbl[7] = mk(2'd0, 2'd1, 32'h8000_8000,   14, 1, 32'h8000_0700, 4'h2, 4'h9,  1,  0, IRQ_RSP_DONE,      32'h8000_0700);

      repeat (3) @(negedge clk);
      chk("rst_state", ttu_state, IRQC_IDLE);
      chk("rst_wid", ttu_wid, 0);
      chk("rst_tid", ttu_tid, 0);
      chk("rst_load_pc", ttu_load_pc, 0);
      chk("rst_load_tmask", ttu_load_tmask, 0);
      chk("rst_load_wmask", ttu_load_wmask, 0);
      chk("rst_rsp_valid", irq_rsp_valid, 0);
      chk("rst_rsp_status", irq_rsp_status, 0);
      chk("rst_rsp_pc", irq_rsp_pc, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      chk("rst_req_ready", irq_req_ready, 1);

      for (int i = 0; i < 8; i++) run_txn(tbl[i]);

      for (int i = 0; i < 12; i++) begin
         v.wid = 2'($urandom_range(0, 3));
         v.tid = 2'($urandom_range(0, 3));
         v.isr_pc = $urandom;
         v.d = $urandom_range(0, 20);
         v.found = 1'($urandom_range(0, 3) != 0);
         v.cur_pc = $urandom;
         v.tmask = 4'($urandom);
         v.wmask = 4'($urandom);
         v.isr_delay = $urandom_range(0, 8);
         v.hold = $urandom_range(0, 3);
         run_txn(model(v));
      end

      // Reset while the ISR is running drops the transaction.
      @(negedge clk);
      irq_req_valid = 1'b1; irq_req_wid = 2'd2; irq_req_tid = 2'd3; irq_req_isr_pc = 32'h8000_9000;
      @(negedge clk);
      irq_req_valid = 1'b0;
      ttu_pipeline_drained = 1'b1; ttu_thread_found = 1'b1;
      ttu_current_pc = 32'h8000_0800; ttu_current_thread_mask = 4'hF; ttu_current_active_warps = 4'hF;
      @(negedge clk);
      chk("rstmid_swap", ttu_state, IRQC_PC_SWAP);
      @(negedge clk);
      chk("rstmid_wait_isr", ttu_state, IRQC_WAIT_ISR);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_state", ttu_state, IRQC_IDLE);
      chk("rstmid_rsp_valid", irq_rsp_valid, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_load_pc", ttu_load_pc, 0);
      reset = 1'b0;
      ttu_pipeline_drained = 1'b0; ttu_thread_found = 1'b0;
      @(negedge clk);
      chk("rstmid_req_ready", irq_req_ready, 1);
      chk("rstmid_idle_hold", ttu_state, IRQC_IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
